// File: rtl/uart_tx.sv
// 8-bit UART transmitter. Serialises one byte per frame onto `tx`, LSB first:
// start bit, 8 data bits, optional parity bit, then 1 or 2 stop bits.
// Bit timing and frame format match the companion rx block so the two can be
// looped back.
//
// Handshake (valid/ready): a byte is transferred on every rising clock edge
// where tx_valid && tx_ready are both high. tx_ready depends only on the FSM
// state (high in IDLE), never on tx_valid. While tx_ready is low, tx_valid
// and tx_data are ignored and nothing is queued. The producer must hold
// tx_data stable with tx_valid until the transfer edge.
module uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int PARITY       = 0,  // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS    = 1   // 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]       shift;
  logic             par_bit;   // parity bit captured from tx_data at accept
  logic             bit_done;

  // The current bit has been held for its full CLKS_PER_BIT cycles.
  assign bit_done  = (baud_cnt == CNT_LAST);

  // Handshake and status derive from the state register only.
  assign tx_ready  = (state == S_IDLE);
  assign tx_busy   = (state != S_IDLE);
  assign dbg_state = state;

  // Frame FSM: tx is registered and updated together with the state so the
  // line level always matches the bit being sent, with no input-to-tx path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (tx_valid) begin
            shift   <= tx_data;
            par_bit <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            state   <= S_START;
            tx      <= 1'b0;
          end
        end

        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // Next data bit is the one about to become shift[0].
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

endmodule
